// File: rtl/led_pkg.sv
// Shared definitions for the LED PWM fader: mode encodings and field width.
package led_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF     = 2'b00,
    MODE_SOLID   = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

endpackage

// File: rtl/pwm_channel.sv
// One LED channel: shadow/active configuration, breathe ramp state and the
// duty selection that feeds the shared PWM comparator in the top level.
module pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [MODE_W-1:0]   mode,
  input  logic [PWM_BITS-1:0] level,
  input  logic                cfg_we,
  input  logic                wrap,
  input  logic                blink_phase,
  output logic [PWM_BITS-1:0] duty
);

  mode_t               shadow_mode_r;
  logic [PWM_BITS-1:0] shadow_level_r;
  mode_t               active_mode_r;
  logic [PWM_BITS-1:0] active_level_r;
  logic [PWM_BITS-1:0] bri_r;
  logic                dir_up_r;

  mode_t               next_mode_s;
  logic [PWM_BITS-1:0] next_level_s;
  logic [PWM_BITS-1:0] bri_next_s;
  logic                dir_up_next_s;

  // Shadow contents as seen at this edge; a strobe in the wrap cycle counts.
  always_comb begin
    next_mode_s  = shadow_mode_r;
    next_level_s = shadow_level_r;
    if (cfg_we) begin
      next_mode_s  = mode_t'(mode);
      next_level_s = level;
    end else begin
      next_mode_s  = shadow_mode_r;
      next_level_s = shadow_level_r;
    end
  end

  // Breathe ramp step for the frame that starts at the coming wrap.
  always_comb begin
    bri_next_s    = bri_r;
    dir_up_next_s = dir_up_r;
    if ((next_mode_s != MODE_BREATHE) || (active_mode_r != MODE_BREATHE)) begin
      // Not breathing, or just entering breathe: start from dark, rising.
      bri_next_s    = '0;
      dir_up_next_s = 1'b1;
    end else if (next_level_s == '0) begin
      bri_next_s    = '0;
      dir_up_next_s = 1'b1;
    end else if (bri_r > next_level_s) begin
      // Peak lowered under the current brightness: clamp and descend.
      bri_next_s    = next_level_s;
      dir_up_next_s = 1'b0;
    end else if (dir_up_r) begin
      if (bri_r == next_level_s) begin
        bri_next_s    = bri_r - PWM_BITS'(1);
        dir_up_next_s = 1'b0;
      end else begin
        bri_next_s    = bri_r + PWM_BITS'(1);
        dir_up_next_s = 1'b1;
      end
    end else begin
      if (bri_r == '0) begin
        bri_next_s    = PWM_BITS'(1);
        dir_up_next_s = 1'b1;
      end else begin
        bri_next_s    = bri_r - PWM_BITS'(1);
        dir_up_next_s = 1'b0;
      end
    end
  end

  // Shadow capture on strobe; active config and ramp advance only at wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_mode_r  <= MODE_OFF;
      shadow_level_r <= '0;
      active_mode_r  <= MODE_OFF;
      active_level_r <= '0;
      bri_r          <= '0;
      dir_up_r       <= 1'b1;
    end else begin
      shadow_mode_r  <= next_mode_s;
      shadow_level_r <= next_level_s;
      if (wrap) begin
        active_mode_r  <= next_mode_s;
        active_level_r <= next_level_s;
        bri_r          <= bri_next_s;
        dir_up_r       <= dir_up_next_s;
      end
    end
  end

  // Duty selection from the active mode.
  always_comb begin
    duty = '0;
    case (active_mode_r)
      MODE_OFF:     duty = '0;
      MODE_SOLID:   duty = active_level_r;
      MODE_BLINK:   duty = blink_phase ? active_level_r : '0;
      MODE_BREATHE: duty = bri_r;
      default:      duty = '0;
    endcase
  end

endmodule

// File: rtl/pwm_fader.sv
// Multi-channel LED PWM fader: shared prescaler, PWM counter and blink
// phase; per-channel duty from pwm_channel; registered active-low pins.
module pwm_fader
  import led_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int PWM_BITS   = 8,
  parameter int PRESCALER  = 3,
  parameter int BLINK_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MODE_W*CHANNELS-1:0]   mode,
  input  logic [PWM_BITS*CHANNELS-1:0] level,
  input  logic                         cfg_we,
  output logic [CHANNELS-1:0]          pwm_n,
  output logic                         frame
);

  logic                  tick_s;
  logic                  wrap_s;
  logic [PWM_BITS-1:0]   pwm_cnt_r;
  logic [BLINK_BITS-1:0] blink_cnt_r;
  logic                  blink_phase_r;
  logic                  frame_r;
  logic [CHANNELS-1:0]   pwm_n_r;
  logic [PWM_BITS-1:0]   duty_s [CHANNELS];

  generate
    if (PRESCALER == 0) begin : g_no_presc
      assign tick_s = 1'b1;
    end else begin : g_presc
      logic [PRESCALER-1:0] presc_cnt_r;

      // Free-running prescaler; tick when it reaches all ones.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          presc_cnt_r <= '0;
        end else begin
          presc_cnt_r <= presc_cnt_r + PRESCALER'(1);
        end
      end

      assign tick_s = &presc_cnt_r;
    end
  endgenerate

  assign wrap_s = tick_s & (&pwm_cnt_r);

  // PWM counter, blink frame counter/phase and the frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt_r     <= '0;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b0;
      frame_r       <= 1'b0;
    end else begin
      frame_r <= wrap_s;
      if (tick_s) begin
        pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      end
      if (wrap_s) begin
        blink_cnt_r <= blink_cnt_r + BLINK_BITS'(1);
        if (&blink_cnt_r) begin
          blink_phase_r <= ~blink_phase_r;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      pwm_channel #(
        .PWM_BITS (PWM_BITS)
      ) u_ch (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode[MODE_W*g +: MODE_W]),
        .level       (level[PWM_BITS*g +: PWM_BITS]),
        .cfg_we      (cfg_we),
        .wrap        (wrap_s),
        .blink_phase (blink_phase_r),
        .duty        (duty_s[g])
      );
    end
  endgenerate

  // Pin drive: LED on (low) while the counter is below the channel duty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_n_r <= '1;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_n_r[i] <= ~(pwm_cnt_r < duty_s[i]);
      end
    end
  end

  assign pwm_n = pwm_n_r;
  assign frame = frame_r;

endmodule
